// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
// State encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell used by the serial adder datapath.
// Purely combinational: sum and carry-out of three input bits.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_cout
);

  assign o_s    = i_a ^ i_b ^ i_c;
  assign o_cout = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Results are registered on the last bit and held until the next one.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic w_s;
  logic w_cout;

  full_adder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_c    (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_acc_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= SHIFT;
            r_a_sr  <= a;
            r_b_sr  <= sub ? ~b : b;
            r_carry <= sub | cin;
            r_cnt   <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          r_acc_sr <= {w_s, r_acc_sr[WIDTH-1:1]};
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            // Overflow: carry into the MSB differs from carry out of it
            sum     <= {w_s, r_acc_sr[WIDTH-1:1]};
            cout    <= w_cout;
            ovf     <= w_cout ^ r_carry;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic reference model
// with per-cycle comparison plus directed literal cases.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } res_t;

  function automatic res_t calc(input logic [W-1:0] x,
                                input logic [W-1:0] y,
                                input logic m,
                                input logic ci);
    res_t r;
    logic [W-1:0] yy;
    logic [W:0]   full;
    yy   = m ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + (m ? 1 : ci);
    r.s  = full[W-1:0];
    r.c  = full[W];
    r.v  = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: a transaction takes W cycles, then done for one
  int   m_left;
  logic m_done;
  res_t m_pend;
  res_t m_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_pend <= calc(a, b, sub, cin);
        m_left <= W;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_done));
    chk("sum",  32'(sum),  32'(m_res.s));
    chk("cout", 32'(cout), 32'(m_res.c));
    chk("ovf",  32'(ovf),  32'(m_res.v));
  end

  // Caller must be at a negedge; leaves start low one cycle later
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                       input logic ts, input logic tc);
    a = ta; b = tb2; sub = ts; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      errors++;
      $display("FAIL timeout: done not seen after %0d cycles", lat);
    end
  endtask

  task automatic op(input string nm, input logic [W-1:0] ta,
                    input logic [W-1:0] tb2, input logic ts,
                    input logic tc, input logic [W-1:0] es,
                    input logic ec, input logic ev);
    int lat;
    issue(ta, tb2, ts, tc);
    wait_done(lat);
    chk({nm, "_lat"}, 32'(lat), 32'(W + 1));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf), 32'(ev));
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("add1", 8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0);
    op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op("sovf", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    op("cin", 8'h10, 8'h01, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
    op("sub1", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    op("sub2", 8'h07, 8'h05, 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);

    // start pulse mid-SHIFT must be ignored
    issue(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    issue(8'hAA, 8'h55, 1'b1, 1'b1);
    wait_done(lat);
    chk("ign_sum", 32'(sum), 32'h30);

    // back-to-back restart from the DONE cycle
    issue(8'h01, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    chk("b2b_lat", 32'(lat), 32'(W + 1));
    chk("b2b_sum", 32'(sum), 32'h02);

    // asynchronous reset in the middle of a shift
    repeat (2) @(negedge clk);
    issue(8'h40, 8'h40, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      chk("arst_nodone", 32'(done), 32'd0);
    end
    op("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0);

    // randomized traffic, including starts during SHIFT and in DONE
    for (int i = 0; i < 3000; i++) begin
      a     = W'($urandom);
      b     = W'($urandom);
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      start = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder/subtractor built around one `full_adder` cell. It latches two operands on a start pulse and shifts them LSB-first through the cell, one bit per clock. Each cycle it feeds the cell the current operand bits plus the stored carry, and captures the cell's S/Cout. It supplies the partial-product accumulation path of the Vedic multiplier where area matters more than latency. Results come out on a one-cycle done strobe and are held until the next result.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0 = a+b+cin, 1 = a−b (b inverted, cin forced to 1); sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- cin  in  1  carry-in for add mode; ignored when sub=1
- busy  out  1  high while bits are being shifted
- done  out  1  one-cycle strobe: sum/cout/ovf just updated
- sum  out  WIDTH  result, held between operations
- cout  out  1  final carry-out (no-borrow flag in sub mode)
- ovf  out  1  two's-complement overflow of last operation

## Operation
- Decided: one clock `clk`; reset `rst` is asynchronous and active-high.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1 → SHIFT. Capture a into a_sr and (sub ? ~b : b) into b_sr. Carry reg ← (sub ? 1 : cin). bit counter ← 0.
- SHIFT, each cycle:
  - full_adder inputs: a_sr[0], b_sr[0], carry.
  - S shifts into the MSB of acc_sr; acc_sr, a_sr and b_sr all shift right by one.
  - carry ← Cout; prev_carry ← old carry; counter increments.
- SHIFT with counter = WIDTH−1 (last bit):
  - sum ← final acc_sr value, including this cycle's S.
  - cout ← Cout.
  - ovf ← Cout XOR carry-into-MSB, where carry-into-MSB is the carry value at this cycle.
  - Next state: DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 → SHIFT (new operands captured, back-to-back allowed).
  - Otherwise → IDLE.
- start during SHIFT is ignored; operands are not re-sampled.
- sum/cout/ovf change only on the SHIFT→DONE edge and hold otherwise, including through IDLE.
- Arithmetic is modulo 2^WIDTH. cout is bit WIDTH of the full (WIDTH+1)-bit sum.
- Counter width: $clog2(WIDTH).

## Timing
- Reset: state=IDLE. busy, done, sum, cout, ovf, carry, counter and shift registers all 0.
- Reset asserted mid-SHIFT aborts the operation immediately. Outputs go to reset values with no done strobe. The first start after deassertion behaves normally.
- start sampled at edge 0 → busy high from edge 0 through edge WIDTH. done high for the cycle after edge WIDTH. Latency is WIDTH+1 clocks from start to done.
- Throughput with back-to-back starts: one result per WIDTH+1 clocks.
- busy = (state==SHIFT); done = (state==DONE). Both are registered-state decodes with no combinational path from inputs.

## Structure
- Shared package `serial_adder_pkg`:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH.
- One sub-module: the existing `full_adder` cell (a, b, c → S, Cout), instantiated once. All other logic (FSM, shift registers, counter, result registers) is local.

## Test plan
- WIDTH=8, a=8'h3C, b=8'h0F, cin=0, sub=0, start for 1 cycle → busy for 8 cycles, done in cycle 9, sum=8'h4B, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1, ovf=0. Then a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
- sub=1, a=8'h05, b=8'h07 → sum=8'hFE, cout=0, ovf=0. Then a=8'h07, b=8'h05 → sum=8'h02, cout=1.
- start with a=8'h10, b=8'h20; pulse start with a=8'hAA mid-SHIFT → ignored, sum=8'h30.
- start held in the DONE cycle with new operands a=8'h01, b=8'h01 → immediate re-entry to SHIFT, next done after 9 more cycles, sum=8'h02.
- rst pulsed at SHIFT bit 4 → all outputs 0 asynchronously, no done. Next start with a=8'h01, b=8'h02 → sum=8'h03.
